// File: rtl/muldiv_pkg.sv
// Shared types and constants for the iterative RV32M multiply/divide unit.
package muldiv_pkg;

    localparam int MDU_ITER    = 32;
    localparam int MDU_LATENCY = 33;

    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } mdu_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } mdu_state_t;

endpackage

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide: MSB-first shift-add multiply and restoring
// divide sharing one 64-bit accumulator, fixed 33-cycle start-to-done latency.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 5
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [2:0]               funct3,
    input  logic [DATA_WIDTH-1:0]    op_a,
    input  logic [DATA_WIDTH-1:0]    op_b,
    input  logic [ADDRESS_WIDTH-1:0] rd_in,
    output logic                     busy,
    output logic                     done,
    output logic [DATA_WIDTH-1:0]    result,
    output logic [ADDRESS_WIDTH-1:0] rd_out
);

    localparam int W  = DATA_WIDTH;
    localparam int CW = $clog2(W);
    localparam logic [CW-1:0] LAST_ITER = CW'(MDU_ITER - 1);

    mdu_state_t             state_reg;
    mdu_op_t                op_reg;
    logic [ADDRESS_WIDTH-1:0] rd_reg;
    logic [W-1:0]           a_abs_reg;
    logic [W-1:0]           b_abs_reg;
    logic                   neg_reg;
    logic                   div0_reg;
    logic                   ovf_reg;
    logic [2*W-1:0]         acc_reg;
    logic [CW-1:0]          cnt_reg;

    // Accept-time operand conditioning
    mdu_op_t      op_in;
    logic         a_signed, b_signed, a_neg, b_neg, neg_in, div0_in, ovf_in;
    logic [W-1:0] a_abs_in, b_abs_in;

    always_comb begin
        op_in    = mdu_op_t'(funct3);
        a_signed = (op_in == OP_MULH) || (op_in == OP_MULHSU) ||
                   (op_in == OP_DIV)  || (op_in == OP_REM);
        b_signed = (op_in == OP_MULH) || (op_in == OP_DIV) || (op_in == OP_REM);
        a_neg    = a_signed && op_a[W-1];
        b_neg    = b_signed && op_b[W-1];
        a_abs_in = a_neg ? -op_a : op_a;
        b_abs_in = b_neg ? -op_b : op_b;
        // Remainders follow the dividend; everything else follows sign(a)^sign(b)
        neg_in   = ((op_in == OP_REM) || (op_in == OP_REMU)) ? a_neg : (a_neg ^ b_neg);
        div0_in  = (op_b == '0);
        ovf_in   = (op_in == OP_DIV || op_in == OP_REM) &&
                   (op_a == {1'b1, {(W-1){1'b0}}}) && (op_b == '1);
    end

    // One iteration of the shared datapath, operands consumed MSB first
    logic [CW-1:0]  idx;
    logic [W:0]     rem_trial, rem_diff;
    logic [2*W-1:0] acc_next;

    always_comb begin
        idx       = CW'(W - 1) - cnt_reg;
        rem_trial = {acc_reg[2*W-1:W], a_abs_reg[idx]};
        rem_diff  = rem_trial - {1'b0, b_abs_reg};
        if (op_reg[2]) begin
            if (!rem_diff[W])
                acc_next = {rem_diff[W-1:0], acc_reg[W-2:0], 1'b1};
            else
                acc_next = {rem_trial[W-1:0], acc_reg[W-2:0], 1'b0};
        end else begin
            acc_next = {acc_reg[2*W-2:0], 1'b0} +
                       (b_abs_reg[idx] ? {{W{1'b0}}, a_abs_reg} : {(2*W){1'b0}});
        end
    end

    // Final result built from the last iteration so it can be registered in DONE
    logic [2*W-1:0] prod_fix;
    logic [W-1:0]   quot, remd, result_next;

    always_comb begin
        prod_fix    = neg_reg ? -acc_next : acc_next;
        quot        = acc_next[W-1:0];
        remd        = acc_next[2*W-1:W];
        result_next = '0;
        case (op_reg)
            OP_MUL:                       result_next = prod_fix[W-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: result_next = prod_fix[2*W-1:W];
            OP_DIV, OP_DIVU: begin
                if (div0_reg)      result_next = '1;
                else if (ovf_reg)  result_next = {1'b1, {(W-1){1'b0}}};
                else               result_next = neg_reg ? -quot : quot;
            end
            default: begin
                // Divide-by-zero returns the original dividend, rebuilt from |a| and its sign
                if (div0_reg)      result_next = neg_reg ? -a_abs_reg : a_abs_reg;
                else if (ovf_reg)  result_next = '0;
                else               result_next = neg_reg ? -remd : remd;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            op_reg    <= OP_MUL;
            rd_reg    <= '0;
            a_abs_reg <= '0;
            b_abs_reg <= '0;
            neg_reg   <= 1'b0;
            div0_reg  <= 1'b0;
            ovf_reg   <= 1'b0;
            acc_reg   <= '0;
            cnt_reg   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            result    <= '0;
            rd_out    <= '0;
        end else begin
            case (state_reg)
                CALC: begin
                    acc_reg <= acc_next;
                    cnt_reg <= cnt_reg + 1'b1;
                    if (cnt_reg == LAST_ITER) begin
                        state_reg <= DONE;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        result    <= result_next;
                        rd_out    <= rd_reg;
                    end
                end
                default: begin
                    done <= 1'b0;
                    if (start) begin
                        state_reg <= CALC;
                        busy      <= 1'b1;
                        op_reg    <= op_in;
                        rd_reg    <= rd_in;
                        a_abs_reg <= a_abs_in;
                        b_abs_reg <= b_abs_in;
                        neg_reg   <= neg_in;
                        div0_reg  <= div0_in;
                        ovf_reg   <= ovf_in;
                        acc_reg   <= '0;
                        cnt_reg   <= '0;
                    end else begin
                        state_reg <= IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative RV32M multiply/divide unit sitting in the execute stage directly downstream of the register file. It consumes the two read operands (RD1/RD2) and the destination register index, then computes the M-extension result over a fixed number of cycles. It returns the result, destination index and a one-cycle write strobe toward the register-file write port (WD3/AD3/WE3). It also raises `busy` so the control path can stall issue.

## Interface
- `DATA_WIDTH`, 32: operand and result width.
- `ADDRESS_WIDTH`, 5: register index width.
- `clk` in 1: single clock; all state updates on posedge.
- `rst` in 1: reset, synchronous, active-high.
- `start` in 1: request; operands are sampled when accepted.
- `funct3` in 3: operation select, RV32M encoding:
  - 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU
  - 100 DIV, 101 DIVU, 110 REM, 111 REMU
- `op_a` in DATA_WIDTH: rs1 value (from RD1).
- `op_b` in DATA_WIDTH: rs2 value (from RD2).
- `rd_in` in ADDRESS_WIDTH: destination register index.
- `busy` out 1: operation in progress; new `start` is ignored.
- `done` out 1: one-cycle pulse; `result` and `rd_out` are valid.
- `result` out DATA_WIDTH: computed value; drives WD3.
- `rd_out` out ADDRESS_WIDTH: latched `rd_in`; drives AD3.

## Operation
- FSM states: IDLE, CALC, DONE.
- IDLE or DONE with `start`=1: latch funct3, rd_in, |op_a|, |op_b| and the result sign; clear the 64-bit accumulator and the 5-bit iteration counter; go to CALC.
- Operand sign handling: signed for MULH, DIV and REM; op_a only for MULHSU; unsigned otherwise.
- CALC performs exactly 32 iterations, then goes to DONE.
  - Multiply: radix-2 shift-add on a 64-bit product.
  - Divide: restoring, one quotient bit per cycle.
- DONE lasts one cycle with `done`=1; then IDLE unless a new `start` is accepted.
- Result selection:
  - MUL: low 32 bits of the product.
  - MULH/MULHSU/MULHU: high 32 bits, after two's-complement negation of the full 64-bit product when the result sign is negative.
  - DIV/DIVU: quotient, negated if the operand signs differ.
  - REM/REMU: remainder, carrying the sign of the dividend.
- Division by zero: quotient = all ones, remainder = op_a.
- Signed overflow (0x80000000 / 0xFFFFFFFF): quotient = 0x80000000, remainder = 0.
- Both special cases still take full latency; the flags are latched at accept time and the iterative datapath result is overridden.
- `start` while in CALC is ignored; no queueing.
- `result` and `rd_out` hold their value from DONE until the next DONE.
- Reset values: state IDLE; `busy`=0, `done`=0, `result`=0, `rd_out`=0; counter and accumulator 0.

## Timing
- `start` accepted in cycle N.
- `busy`=1 in cycles N+1..N+32.
- `done`=1 in cycle N+33; `busy`=0 in that cycle.
- Fixed latency: 33 cycles start-to-done for every funct3, including the special cases.
- `start` in the DONE cycle N+33 is accepted; the next `done` is at N+66. Throughput is one op per 33 cycles.
- `rst` mid-CALC: IDLE on the next edge, no `done` pulse, and `result`/`rd_out` return to 0.
- `rst` takes precedence over a simultaneous `start`.
- All outputs are registered; no combinational path from inputs to outputs.

## Structure
- Shared package `muldiv_pkg`:
  - `mdu_op_t` enum for the funct3 encodings.
  - `mdu_state_t` enum (IDLE/CALC/DONE).
  - constants `MDU_ITER` = 32 and `MDU_LATENCY` = 33.
- Single module, no sub-module.
  - Multiply and divide share the 64-bit accumulator and the iteration counter.
  - Negation and absolute-value logic is inline.

## Test plan
- MUL 0x00000007 × 0xFFFFFFFD, rd_in=5, start at N → `done` exactly at N+33, `result`=0xFFFFFFEB, `rd_out`=5, `busy` high N+1..N+32.
- High-half products:
  - MULH 0x80000000 × 0x80000000 → 0x40000000.
  - MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE.
  - MULHSU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFF.
- Divide/remainder:
  - DIV −7/2 → 0xFFFFFFFD; REM −7/2 → 0xFFFFFFFF.
  - DIVU 100/7 → 14; REMU 100/7 → 2.
- Division special cases:
  - DIV 5/0 → 0xFFFFFFFF; REM 5/0 → 5; DIVU 5/0 → 0xFFFFFFFF.
  - DIV 0x80000000/0xFFFFFFFF → 0x80000000; REM → 0.
  - All still complete at N+33.
- Handshake:
  - `start` with different operands at N+10 → ignored; the first result is unchanged at N+33.
  - `start` asserted in the DONE cycle → accepted; second `done` at N+66 with the second result.
- Reset mid-operation:
  - `rst` pulsed at N+15 → `busy`=0 at N+16, no `done` pulse through N+40, `result`=0.
  - Then a fresh MUL 3×4 → 12 after 33 cycles.
